irq_claim_arbiter: RTL and testbench

Claim/complete scheduler that sits between the interrupt controller's pending/enable/priority state and the CPU trap path. It scans sources sequentially, one per cycle, to find the highest-priority eligible source above a threshold, and raises ext_irq_o. It serves CPU claim and complete handshakes, issues pending-clear pulses back to the controller, and tracks in-flight sources so that no source is re-presented before it completes.

---
 rtl/irq_pkg.sv | 10 +
 rtl/irq_inflight_tracker.sv | 27 ++
 rtl/irq_claim_arbiter.sv | 91 +++++++++
 tb/tb_irq_claim_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the interrupt claim arbiter
package irq_pkg;
  localparam int NSOURCES_DEF = 32;
  localparam int PRIO_W_DEF = 3;
  localparam int IRQ_IDW = $clog2(NSOURCES_DEF);
  typedef logic [IRQ_IDW-1:0] irq_id_t;
  typedef logic [PRIO_W_DEF-1:0] irq_prio_t;
  typedef enum logic [1:0] {IDLE, SCAN, READY} arb_state_e;
  localparam irq_id_t IRQ_ID_NONE = '0;
endpackage

// File: rtl/irq_inflight_tracker.sv
// irq_inflight_tracker: records sources that have been claimed but not yet completed
module irq_inflight_tracker
  import irq_pkg::*;
#(
  parameter int NSOURCES = NSOURCES_DEF,
  parameter int IDW = $clog2(NSOURCES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [IDW-1:0]      set_id,
  input  logic                clr_en,
  input  logic [IDW-1:0]      clr_id,
  output logic [NSOURCES-1:0] inflight
);
  logic [NSOURCES-1:0] set_mask, clr_mask;
  // only real, currently in-flight IDs may be completed; anything else is dropped
  always_comb begin
    set_mask = set_en ? NSOURCES'(1) << set_id : '0;
    clr_mask = (clr_en && clr_id != '0 && 32'(clr_id) < NSOURCES) ? (NSOURCES'(1) << clr_id) & inflight : '0;
  end
  // claim and complete of different IDs both land in the same cycle
  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else inflight <= (inflight | set_mask) & ~clr_mask;
  end
endmodule

// File: rtl/irq_claim_arbiter.sv
// irq_claim_arbiter: sequential priority scan with CPU claim/complete handshakes
module irq_claim_arbiter
  import irq_pkg::*;
#(
  parameter int NSOURCES = NSOURCES_DEF,
  parameter int PRIO_W = PRIO_W_DEF,
  parameter int IDW = $clog2(NSOURCES)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NSOURCES-1:0]        pending_i,
  input  logic [NSOURCES-1:0]        enable_i,
  input  logic [NSOURCES*PRIO_W-1:0] priority_i,
  input  logic [PRIO_W-1:0]          threshold_i,
  input  logic                       claim_req_i,
  output logic                       claim_ack_o,
  output logic [IDW-1:0]             claim_id_o,
  input  logic                       complete_i,
  input  logic [IDW-1:0]             complete_id_i,
  output logic [NSOURCES-1:0]        clear_pending_o,
  output logic                       ext_irq_o,
  output logic                       busy_o
);
  arb_state_e state;
  logic [IDW-1:0] idx, best_id, nbest_id;
  logic [PRIO_W-1:0] best_prio, nbest_prio;
  logic [PRIO_W-1:0] prio [NSOURCES];
  logic [NSOURCES-1:0] elig, snap, inflight;
  logic claim_ok, take, cand, last, restart;
  irq_inflight_tracker #(.NSOURCES(NSOURCES), .IDW(IDW)) u_tracker (
    .clk(clk_i), .rst(rst_i), .set_en(take), .set_id(best_id),
    .clr_en(complete_i), .clr_id(complete_id_i), .inflight(inflight)
  );
  // live eligibility of every source; index 0 is the reserved "none" ID
  always_comb begin
    for (int i = 0; i < NSOURCES; i++) begin
      prio[i] = priority_i[i*PRIO_W +: PRIO_W];
      elig[i] = i != 0 && pending_i[i] && enable_i[i] && !inflight[i] && prio[i] > threshold_i;
    end
  end
  // scan step against the snapshot so late changes wait for the next scan
  always_comb begin
    claim_ok = state == READY && elig[best_id];
    take = claim_req_i && claim_ok;
    cand = snap[idx] && prio[idx] > best_prio;
    nbest_id = cand ? idx : best_id;
    nbest_prio = cand ? prio[idx] : best_prio;
    last = idx == IDW'(NSOURCES - 1);
    restart = (state == IDLE && |elig) || (state == READY && (elig != snap || !elig[best_id]));
  end
  // FSM with registered claim response, clear pulse, irq and busy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      snap <= '0;
      idx <= '0;
      best_id <= '0;
      best_prio <= '0;
      ext_irq_o <= 1'b0;
      busy_o <= 1'b0;
      claim_ack_o <= 1'b0;
      claim_id_o <= '0;
      clear_pending_o <= '0;
    end else begin
      claim_ack_o <= claim_req_i;
      claim_id_o <= take ? best_id : IDW'(IRQ_ID_NONE);
      clear_pending_o <= take ? NSOURCES'(1) << best_id : '0;
      if (take) begin
        state <= IDLE;
        ext_irq_o <= 1'b0;
      end else if (restart) begin
        state <= SCAN;
        busy_o <= 1'b1;
        ext_irq_o <= 1'b0;
        snap <= elig;
        idx <= IDW'(1);
        best_id <= '0;
        best_prio <= '0;
      end else if (state == SCAN) begin
        best_id <= nbest_id;
        best_prio <= nbest_prio;
        idx <= idx + IDW'(1);
        if (last) begin
          state <= nbest_id != '0 ? READY : IDLE;
          busy_o <= 1'b0;
          ext_irq_o <= nbest_id != '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_irq_claim_arbiter.sv
// tb_irq_claim_arbiter: directed checks of scan, claim, complete and reset behaviour
module tb_irq_claim_arbiter;
  logic clk = 0, rst = 1;
  logic [31:0] pending = '0, enable = '1, clear_pending;
  logic [95:0] prio_v = '0;
  logic [2:0] threshold = '0;
  logic claim_req = 0, claim_ack, complete = 0, ext_irq, busy;
  logic [4:0] claim_id, complete_id = '0;
  int checks = 0, failures = 0, waited = 0;

  irq_claim_arbiter dut (
    .clk_i(clk), .rst_i(rst), .pending_i(pending), .enable_i(enable),
    .priority_i(prio_v), .threshold_i(threshold), .claim_req_i(claim_req),
    .claim_ack_o(claim_ack), .claim_id_o(claim_id), .complete_i(complete),
    .complete_id_i(complete_id), .clear_pending_o(clear_pending),
    .ext_irq_o(ext_irq), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_prio(input int i, input int p);
    prio_v[i*3 +: 3] = 3'(p);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    waited = 0;
    while (!ext_irq && waited < budget) begin
      tick;
      waited++;
    end
    chk(tag, ext_irq, 1);
  endtask

  task automatic do_complete(input int id);
    complete = 1;
    complete_id = 5'(id);
    tick;
    complete = 0;
    complete_id = '0;
  endtask

  task automatic claim_chk(input string tag, input int exp_id);
    claim_req = 1;
    tick;
    claim_req = 0;
    chk({tag, "_ack"}, claim_ack, 1);
    chk({tag, "_id"}, claim_id, exp_id);
    chk({tag, "_clr"}, clear_pending, exp_id == 0 ? 32'd0 : 32'd1 << exp_id);
    tick;
    chk({tag, "_ack_low"}, claim_ack, 0);
    chk({tag, "_id_low"}, claim_id, 0);
    chk({tag, "_clr_low"}, clear_pending, 0);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_irq", ext_irq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", claim_ack, 0);
    chk("rst_id", claim_id, 0);
    chk("rst_clr", clear_pending, 0);
    rst = 0;
    // single source 5
    pending = 32'h20;
    set_prio(5, 3);
    tick;
    chk("t1_busy", busy, 1);
    chk("t1_irq_scan", ext_irq, 0);
    wait_irq("t1_irq", 40);
    chk("t1_scan_len", waited, 31);
    chk("t1_busy_ready", busy, 0);
    claim_req = 1;
    tick;
    claim_req = 0;
    chk("t1_ack", claim_ack, 1);
    chk("t1_id", claim_id, 5);
    chk("t1_clr", clear_pending, 32'h20);
    chk("t1_irq_drop", ext_irq, 0);
    tick;
    chk("t1_clr_once", clear_pending, 0);
    chk("t1_ack_once", claim_ack, 0);
    pending = '0;
    do_complete(5);
    set_prio(5, 0);
    tick;
    // priority order and tie to lowest ID
    pending = (32'd1 << 3) | (32'd1 << 9) | (32'd1 << 12);
    set_prio(3, 4);
    set_prio(9, 4);
    set_prio(12, 6);
    tick;
    wait_irq("t2_irq_a", 40);
    claim_chk("t2_c12", 12);
    pending[12] = 0;
    wait_irq("t2_irq_b", 40);
    claim_chk("t2_c3", 3);
    wait_irq("t2_irq_c", 40);
    claim_chk("t2_c9", 9);
    pending = '0;
    do_complete(12);
    do_complete(3);
    do_complete(9);
    prio_v = '0;
    tick;
    // threshold blocks equal and lower priorities
    threshold = 3'd4;
    pending = (32'd1 << 10) | (32'd1 << 11);
    set_prio(10, 4);
    set_prio(11, 2);
    repeat (40) tick;
    chk("t3_irq_none", ext_irq, 0);
    chk("t3_busy_none", busy, 0);
    claim_chk("t3_c0", 0);
    set_prio(10, 5);
    tick;
    wait_irq("t3_irq", 40);
    chk("t3_scan_len", waited, 31);
    claim_chk("t3_c10", 10);
    pending = '0;
    do_complete(10);
    threshold = '0;
    prio_v = '0;
    tick;
    // in-flight source is not re-presented until completed
    pending = 32'd1 << 7;
    set_prio(7, 3);
    tick;
    wait_irq("t4_irq_a", 40);
    claim_chk("t4_c7", 7);
    do_complete(0);
    repeat (40) tick;
    chk("t4_inflight_irq", ext_irq, 0);
    chk("t4_inflight_busy", busy, 0);
    do_complete(7);
    do_complete(7);
    wait_irq("t4_irq_b", 40);
    claim_chk("t4_c7_again", 7);
    pending = '0;
    do_complete(7);
    tick;
    // claim during scan, then reset mid-scan
    pending = 32'd1 << 7;
    tick;
    chk("t5_busy", busy, 1);
    claim_chk("t5_c0_scan", 0);
    chk("t5_still_busy", busy, 1);
    wait_irq("t5_irq", 40);
    claim_chk("t5_c7", 7);
    pending[14] = 1;
    set_prio(14, 5);
    tick;
    chk("t5_busy2", busy, 1);
    repeat (5) tick;
    rst = 1;
    tick;
    rst = 0;
    chk("t5_rst_irq", ext_irq, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_clr", clear_pending, 0);
    tick;
    wait_irq("t5_irq_b", 40);
    claim_chk("t5_c14", 14);
    wait_irq("t5_irq_c", 40);
    claim_chk("t5_c7_rst", 7);
    pending = '0;
    prio_v = '0;
    rst = 1;
    tick;
    rst = 0;
    // new higher-priority source forces a rescan from READY
    pending = 32'd1 << 4;
    set_prio(4, 2);
    tick;
    wait_irq("t6_irq_a", 40);
    pending[20] = 1;
    set_prio(20, 5);
    tick;
    chk("t6_rescan_irq", ext_irq, 0);
    chk("t6_rescan_busy", busy, 1);
    wait_irq("t6_irq_b", 40);
    claim_chk("t6_c20", 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
